// File: rtl/ws2812_pattern_gen.sv
// LED pattern engine: renders solid / rainbow / spread / chase frames into a shadow buffer
// and commits each completed frame atomically to the packed colour vector for the ws2812 driver.
module ws2812_pattern_gen #(
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned TICK_DIV   = 65536,
  parameter int unsigned PHASE_STEP = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [7:0]              brightness,
  input  logic [23:0]             solid_rgb,
  output logic [24*NUM_LEDS-1:0]  packed_rgb_data,
  output logic                    frame_strobe
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IdxW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [CntW-1:0] CntMax    = CntW'(TICK_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax    = IdxW'(NUM_LEDS - 1);
  localparam logic [7:0]      PhaseStep = 8'(PHASE_STEP);

  localparam logic [1:0] ModeSolid   = 2'd0;
  localparam logic [1:0] ModeRainbow = 2'd1;
  localparam logic [1:0] ModeSpread  = 2'd2;
  localparam logic [1:0] ModeChase   = 2'd3;

  typedef enum logic [1:0] {StIdle, StFill, StCommit} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          tick_cnt_q;
  logic                     tick;
  logic [IdxW-1:0]          led_idx_q, led_idx_d;
  logic [IdxW-1:0]          chase_q, chase_d;
  logic [7:0]               pos_q, pos_d;
  logic [1:0]               mode_q, mode_d;
  logic [7:0]               bright_q, bright_d;
  logic [23:0]              rgb_q, rgb_d;
  logic [24*NUM_LEDS-1:0]   shadow_q, shadow_d;
  logic [24*NUM_LEDS-1:0]   out_q, out_d;
  logic                     strobe_q, strobe_d;

  logic [7:0]               led_pos;
  logic [23:0]              base_rgb;
  logic [23:0]              led_rgb;

  // Colour wheel, returned as {G,R,B}.
  function automatic logic [23:0] wheel(input logic [7:0] w);
    logic [7:0] v;
    logic [23:0] res;
    if (w < 8'd85) begin
      v   = w;
      res = {8'd0, 8'd255 - 8'd3 * v, 8'd3 * v};
    end else if (w < 8'd170) begin
      v   = w - 8'd85;
      res = {8'd3 * v, 8'd0, 8'd255 - 8'd3 * v};
    end else begin
      v   = w - 8'd170;
      res = {8'd255 - 8'd3 * v, 8'd3 * v, 8'd0};
    end
    return res;
  endfunction

  // (c * (b + 1)) >> 8 so that b = 255 is an exact pass-through.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  assign tick = enable && (tick_cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else if (enable) begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  always_comb begin
    led_pos  = pos_q + 8'(led_idx_q) * PhaseStep;
    base_rgb = 24'd0;
    case (mode_q)
      ModeSolid:   base_rgb = rgb_q;
      ModeRainbow: base_rgb = wheel(pos_q);
      ModeSpread:  base_rgb = wheel(led_pos);
      ModeChase:   base_rgb = (led_idx_q == chase_q) ? rgb_q : 24'd0;
      default:     base_rgb = 24'd0;
    endcase
    led_rgb = {scale(base_rgb[23:16], bright_q),
               scale(base_rgb[15:8],  bright_q),
               scale(base_rgb[7:0],   bright_q)};
  end

  always_comb begin
    state_d   = state_q;
    led_idx_d = led_idx_q;
    chase_d   = chase_q;
    pos_d     = pos_q;
    mode_d    = mode_q;
    bright_d  = bright_q;
    rgb_d     = rgb_q;
    shadow_d  = shadow_q;
    out_d     = out_q;
    strobe_d  = 1'b0;

    case (state_q)
      StIdle: begin
        // Ticks seen outside idle are dropped; TICK_DIV >= NUM_LEDS+2 keeps that from happening.
        if (tick) begin
          mode_d    = mode;
          bright_d  = brightness;
          rgb_d     = solid_rgb;
          led_idx_d = '0;
          state_d   = StFill;
        end
      end
      StFill: begin
        shadow_d[24*led_idx_q +: 24] = led_rgb;
        if (led_idx_q == IdxMax) begin
          state_d = StCommit;
        end else begin
          led_idx_d = led_idx_q + 1'b1;
        end
      end
      StCommit: begin
        out_d    = shadow_q;
        strobe_d = 1'b1;
        pos_d    = pos_q + 8'd1;
        if (mode_q == ModeChase) begin
          chase_d = (chase_q == IdxMax) ? '0 : chase_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      led_idx_q <= '0;
      chase_q   <= '0;
      pos_q     <= '0;
      mode_q    <= '0;
      bright_q  <= '0;
      rgb_q     <= '0;
      shadow_q  <= '0;
      out_q     <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_idx_q <= led_idx_d;
      chase_q   <= chase_d;
      pos_q     <= pos_d;
      mode_q    <= mode_d;
      bright_q  <= bright_d;
      rgb_q     <= rgb_d;
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      strobe_q  <= strobe_d;
    end
  end

  assign packed_rgb_data = out_q;
  assign frame_strobe    = strobe_q;

endmodule

// File: doc/ws2812_pattern_gen.md
Name: ws2812_pattern_gen

Overview:
- Parametrised LED pattern engine that produces the packed per-LED colour vector consumed by the ws2812 serial driver.
- Generalises the single rainbow wheel to four modes: solid, uniform rainbow, spread rainbow and chase.
- Adds global brightness scaling and a programmable frame rate.
- Builds each frame in a shadow buffer and commits it atomically, so the driver never sees a half-updated frame. Sits between control logic and the ws2812 instance.

Parameters:
- NUM_LEDS, 8, number of LEDs in the chain (1..256).
- TICK_DIV, 65536, clk cycles per animation step. Must be >= NUM_LEDS+2.
- PHASE_STEP, 32, wheel offset between adjacent LEDs in spread mode (8-bit, mod 256).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous reset, active-low.
- enable  input  1  1 = animation runs; 0 = tick counter holds.
- mode  input  2  0 solid, 1 rainbow, 2 spread, 3 chase.
- brightness  input  8  global scale, 255 = full.
- solid_rgb  input  24  {G,R,B} colour for modes 0 and 3.
- packed_rgb_data  output  24*NUM_LEDS  LED i at bits [24*i +: 24], each LED {G,R,B}.
- frame_strobe  output  1  one-cycle pulse when packed_rgb_data updates.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - packed_rgb_data=0, frame_strobe=0.
  - tick counter=0, wheel pos=0, chase_idx=0, state=IDLE, shadow buffer=0.
  - Reset mid-FILL abandons the frame; the output stays 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable=1 and holds while enable=0.
  - tick=1 in the cycle the count is TICK_DIV-1; the counter then wraps to 0.
- FSM states IDLE, FILL, COMMIT:
  - IDLE: on tick, latch mode, brightness and solid_rgb; set led_idx=0; go to FILL.
  - FILL: each cycle write the colour for led_idx into the shadow buffer and increment led_idx. After writing led_idx=NUM_LEDS-1, go to COMMIT.
  - COMMIT: copy the shadow buffer to packed_rgb_data and pulse frame_strobe=1 for this cycle only. Increment wheel pos mod 256. If the latched mode=3, increment chase_idx, wrapping NUM_LEDS-1 to 0. Go to IDLE.
- Latency: the tick cycle is T; FILL occupies T+1..T+NUM_LEDS; output and frame_strobe change on the edge ending cycle T+NUM_LEDS+1.
- A tick arriving outside IDLE is dropped. This cannot occur when the TICK_DIV constraint is honoured.
- Input changes during FILL have no effect until the next tick.
- enable falling during FILL/COMMIT does not abort; the frame completes.
- Base colour per LED i, using latched values:
  - mode 0: solid_rgb.
  - mode 1: wheel(pos).
  - mode 2: wheel((pos + i*PHASE_STEP) mod 256).
  - mode 3: solid_rgb if i==chase_idx, else 0.
- wheel(w), 8-bit:
  - w<85: R=255-3w, G=0, B=3w.
  - 85<=w<170, v=w-85: R=0, G=3v, B=255-3v.
  - w>=170, v=w-170: R=3v, G=255-3v, B=0.
- Brightness scaling per channel: out = (c * (brightness+1)) >> 8, a 16-bit product truncated to 8 bits. brightness=255 leaves c unchanged; brightness=0 gives c>>8 = 0.
- Wheel pos wraps 255 to 0.

Test Plan:
All scenarios use NUM_LEDS=4, TICK_DIV=16, PHASE_STEP=64.
- Reset/latency: reset_n low for 3 cycles, then high with enable=1, mode=1, brightness=255 -> output 0 until the first frame_strobe. That strobe comes at cycle 16+4+1 after reset release, with every LED = 24'h00FF00.
- Spread: mode=2, brightness=255, first frame -> LEDs 0..3 = 24'h00FF00, 24'h003FC0, 24'h81007E, 24'hBD4200. Next frame LED0 = wheel(1) = 24'h00FC03.
- Brightness: mode=0, solid_rgb=24'hFFFFFF, brightness=127 -> all LEDs 24'h7F7F7F; brightness=0 -> all LEDs 24'h000000.
- Chase: mode=3, solid_rgb=24'h102030 -> over 5 frames, the lit LED index goes 0,1,2,3,0 and every other LED is 0.
- Enable/atomicity: deassert enable mid-FILL -> that frame still commits; no further frame_strobe while enable=0; packed_rgb_data changes only in frame_strobe cycles. Change mode during FILL -> the current frame is unaffected.
- Wrap/reset mid-frame: run 256 frames in mode 1 -> frame 257 LED0 = 24'h00FF00 again. Assert reset_n=0 during FILL -> packed_rgb_data=0 and frame_strobe=0 next cycle.
